// File: rtl/demux_1x2_buf.sv
// Buffered 1:2 stream demux: each word is steered by in_sel into a private DEPTH-entry FIFO per output.
// Latency: 1 cycle, from input acceptance to the registered FIFO head on outk_data/outk_valid.
// Backpressure: in_ready = !full of the selected FIFO only; define DEMUX_1X2_STATS_EN for out1_cnt/out2_cnt.

// Circular-buffer FIFO with wr_ptr/rd_ptr and an occupancy count.
// Latency: a pushed word is visible at the head after the push edge; empty head reads as 0.
// Backpressure: push is ignored when full and pop is ignored when empty.
module demux_1x2_buf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; an empty FIFO masks it to 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end
endmodule

module demux_1x2_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready
`ifdef DEMUX_1X2_STATS_EN
    ,
    output logic [15:0]      out1_cnt,
    output logic [15:0]      out2_cnt
`endif
);
    logic full1;
    logic full2;
    logic empty1;
    logic empty2;
    logic push1;
    logic push2;
    logic pop1;
    logic pop2;

    // Readiness looks only at the full flag, so a same-cycle pop never admits a push.
    assign in_ready   = in_sel ? !full2 : !full1;
    assign push1      = in_valid && in_ready && !in_sel;
    assign push2      = in_valid && in_ready && in_sel;
    assign out1_valid = !empty1;
    assign out2_valid = !empty2;
    assign pop1       = out1_valid && out1_ready;
    assign pop2       = out2_valid && out2_ready;

    demux_1x2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .wdata (in_data),
        .pop   (pop1),
        .rdata (out1_data),
        .full  (full1),
        .empty (empty1)
    );

    demux_1x2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push2),
        .wdata (in_data),
        .pop   (pop2),
        .rdata (out2_data),
        .full  (full2),
        .empty (empty2)
    );

`ifdef DEMUX_1X2_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_cnt <= '0;
            out2_cnt <= '0;
        end else begin
            if (pop1) begin
                out1_cnt <= out1_cnt + 16'd1;
            end
            if (pop2) begin
                out2_cnt <= out2_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_demux_1x2_buf.sv
// Directed bench for demux_1x2_buf with a per-output scoreboard of expected words.
module tb_demux_1x2_buf;
    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out2_data;
    logic       out2_valid;
    logic       out2_ready;
`ifdef DEMUX_1X2_STATS_EN
    logic [15:0] out1_cnt;
    logic [15:0] out2_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    demux_1x2_buf #(.WIDTH(8), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready)
`ifdef DEMUX_1X2_STATS_EN
        ,
        .out1_cnt   (out1_cnt),
        .out2_cnt   (out2_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            step();
        end
        chk("drain_q1_empty", q1.size(), 0);
        chk("drain_q2_empty", q2.size(), 0);
    endtask

    // Scoreboard: outputs are compared first, then accepted inputs are queued.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out1_valid && out1_ready) begin
                if (q1.size() == 0) chk("out1_spurious", out1_valid, 1'b0);
                else                chk("out1_order", out1_data, q1.pop_front());
            end
            if (out2_valid && out2_ready) begin
                if (q2.size() == 0) chk("out2_spurious", out2_valid, 1'b0);
                else                chk("out2_order", out2_data, q2.pop_front());
            end
            if (in_valid && in_ready) begin
                if (in_sel) q2.push_back(in_data);
                else        q1.push_back(in_data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic accepted;
        rst_n      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_out1_valid", out1_valid, 1'b0);
        chk("rst_out2_valid", out2_valid, 1'b0);
        chk("rst_out1_data", out1_data, 8'h00);
        chk("rst_out2_data", out2_data, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        step();

        // Basic routing with both consumers ready
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        in_data = 8'h11; in_sel = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("basic_in_ready", in_ready, 1'b1);
        chk("basic_no_comb_path", out1_valid, 1'b0);
        step();
        in_data = 8'h22; in_sel = 1'b1;
        @(negedge clk);
        chk("basic_lat_out1_valid", out1_valid, 1'b1);
        chk("basic_lat_out1_data", out1_data, 8'h11);
        step();
        in_data = 8'h33; in_sel = 1'b0;
        @(negedge clk);
        chk("basic_lat_out2_data", out2_data, 8'h22);
        chk("basic_out1_idle", out1_valid, 1'b0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("basic_lat_out1_data2", out1_data, 8'h33);
        step();
        drain();

        // Full FIFO 1 while output 2 keeps flowing
        out1_ready = 1'b0;
        out2_ready = 1'b1;
        in_sel = 1'b0; in_valid = 1'b1;
        in_data = 8'hA1; step();
        in_data = 8'hA2; step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_out1_valid", out1_valid, 1'b1);
        chk("full_out1_head", out1_data, 8'hA1);
        chk("full_ready_without_valid", in_ready, 1'b0);
        step();
        in_sel = 1'b1; in_data = 8'hB1; in_valid = 1'b1;
        @(negedge clk);
        chk("full_other_side_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_b1_out2_valid", out2_valid, 1'b1);
        chk("full_b1_out2_data", out2_data, 8'hB1);
        step();
        in_sel = 1'b0; in_data = 8'hA3; in_valid = 1'b1;
        @(negedge clk);
        chk("full_third_attempt", in_ready, 1'b0);
        step();
        out1_ready = 1'b1;
        @(negedge clk);
        chk("full_same_cycle_pop", in_ready, 1'b0);
        step();
        @(negedge clk);
        chk("full_after_pop", in_ready, 1'b1);
        chk("full_after_pop_head", out1_data, 8'hA2);
        step();
        drain();

        // Wrap-around with random stalls
        for (int i = 0; i < 20; i++) begin
            in_data  = 8'($urandom);
            in_sel   = i[0];
            in_valid = 1'b1;
            accepted = 1'b0;
            for (int g = 0; g < 100; g++) begin
                out1_ready = 1'($urandom_range(0, 1));
                out2_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                accepted = in_ready;
                step();
                if (accepted) break;
            end
            chk("wrap_accept", accepted, 1'b1);
        end
        drain();

        // Reset mid-stream with FIFO 1 holding two words
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        in_sel = 1'b0; in_valid = 1'b1;
        in_data = 8'hC1; step();
        in_data = 8'hC2; step();
        in_sel = 1'b1; in_data = 8'hD1; step();
        in_valid = 1'b0;
        chk("mid_fifo1_full", in_sel ? out1_valid : 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        chk("mid_rst_out1_valid", out1_valid, 1'b0);
        chk("mid_rst_out2_valid", out2_valid, 1'b0);
        chk("mid_rst_out1_data", out1_data, 8'h00);
        chk("mid_rst_out2_data", out2_data, 8'h00);
        in_sel = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b1);
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("mid_release_out1_empty", out1_valid, 1'b0);
        chk("mid_release_out2_empty", out2_valid, 1'b0);
        step();

`ifdef DEMUX_1X2_STATS_EN
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        in_sel = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 8'(i);
            step();
        end
        drain();
        chk("stats_out2_cnt", out2_cnt, 16'd300);
        chk("stats_out1_cnt_zero", out1_cnt, 16'd0);
        in_sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            in_data = 8'(i);
            step();
        end
        drain();
        chk("stats_out1_cnt_wrap", out1_cnt, 16'd1);
        chk("stats_out2_cnt_hold", out2_cnt, 16'd300);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_1x2_buf.md
Name: demux_1x2_buf

Overview:
- Buffered 1-to-2 stream demultiplexer; the inverse of the 2:1 select mux in the datapath library.
- Takes one valid/ready input stream and steers each word to output 1 or output 2 according to a per-word select bit.
- Each output has its own DEPTH-entry FIFO, so a stalled consumer on one side never blocks the other side.
- Used where one producer feeds two independently-stalling consumers.

Parameters:
- WIDTH, 8, data width in bits of input and both outputs.
- DEPTH, 2, entries per output FIFO; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_data  input  WIDTH  input word.
- in_sel  input  1  routing select: 0 sends the word to output 1, 1 sends it to output 2.
- in_valid  input  1  input word and in_sel are valid.
- in_ready  output  1  the block accepts the word this cycle.
- out1_data  output  WIDTH  head word of FIFO 1.
- out1_valid  output  1  FIFO 1 is non-empty.
- out1_ready  input  1  consumer 1 takes the head word.
- out2_data  output  WIDTH  head word of FIFO 2.
- out2_valid  output  1  FIFO 2 is non-empty.
- out2_ready  input  1  consumer 2 takes the head word.

Behaviour:
- Reset: rst_n low asynchronously clears both FIFOs (pointers and counts to 0).
  - out1_valid and out2_valid go to 0; out1_data and out2_data go to 0.
  - Storage contents are not cleared.
  - Reset mid-transfer discards all buffered words; nothing is replayed.
- Handshakes:
  - Input transfer occurs on a clock edge where in_valid=1 and in_ready=1.
  - Output k transfer occurs on a clock edge where outk_valid=1 and outk_ready=1.
- in_ready is combinational: in_ready = !full(FIFO selected by in_sel).
  - in_ready is based on the full flag only; a pop from a full FIFO in the same cycle does not free space for a push in that cycle.
  - in_ready may depend on in_sel but never on in_valid.
- Producer rules: must hold in_data and in_sel stable while in_valid=1 and in_ready=0. Must not retract in_valid before the transfer.
- Latency:
  - A word accepted at edge N is visible on outk_data/outk_valid after edge N (registered output, 1 cycle).
  - There is no combinational path from input to output.
- FIFO k:
  - Circular buffer with wr_ptr, rd_ptr, and a count register of log2(DEPTH)+1 bits.
  - Pointers wrap from DEPTH-1 to 0.
  - full = (count == DEPTH); empty = (count == 0).
- outk_valid = !empty.
- outk_data = storage[rd_ptr] when non-empty, else 0.
- Simultaneous push and pop on the same non-full, non-empty FIFO: count unchanged, both pointers advance.
- Push to one FIFO and pop from the other in the same cycle: fully independent.
- Ordering: words are delivered in acceptance order within each output. No ordering relation between the two outputs.
- outk_ready asserted while outk_valid=0: no effect.
- in_valid=0: no state change on the input side.

Optional Feature:
- Macro: DEMUX_1X2_STATS_EN
- Defined: adds output ports out1_cnt and out2_cnt, 16 bits each.
  - Each counts completed output-k transfers, wrapping 0xFFFF to 0x0000.
  - Cleared by rst_n.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with FIFO 1 holding 2 words -> out1_valid=0, out2_valid=0, out1_data=0, out2_data=0, in_ready=1 immediately; FIFO 1 stays empty after release.
- Basic routing (out1_ready=out2_ready=1): drive 0x11/sel0, 0x22/sel1, 0x33/sel0 -> out1 emits 0x11 then 0x33; out2 emits 0x22; each word appears 1 cycle after acceptance.
- Full FIFO (DEPTH=2, out1_ready=0): push 0xA1, 0xA2 with sel=0 -> out1_valid=1, out1_data=0xA1. With in_sel=0, in_ready=0 on the third attempt; with in_sel=1, in_ready=1 and 0xB1 reaches out2 next cycle.
- Full FIFO with same-cycle pop: FIFO 1 full, out1_ready=1 and in_valid=1 with sel=0 -> in_ready=0 that cycle; push accepted the following cycle; no word lost.
- Wrap-around: 20 words alternating sel with random out1_ready/out2_ready stalls -> each output sequence matches the sent order exactly; pointers wrap at least 4 times.
- Stats (DEMUX_1X2_STATS_EN defined): 300 transfers on output 2 -> out2_cnt=300 and out1_cnt=0. Force 65537 transfers on output 1 -> out1_cnt=1.
